// File: rtl/rgmii_tx_pkg.sv
// rtl/rgmii_tx_pkg.sv - shared types, half-period constants and counter sizing for the RGMII TX serializer
package rgmii_tx_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_e;

    localparam int HALF_1000 = 1;
    localparam int HALF_100  = 5;
    localparam int HALF_10   = 50;

    localparam int HALF_W = $clog2(HALF_10 + 1);

`ifdef RGMII_TX_MII_SPEED_EN
    localparam int CNT_W = $clog2(4 * HALF_10);
`else
    localparam int CNT_W = 1;
`endif

    // The reserved 2'b11 encoding falls into the default branch and runs at gigabit rate.
    function automatic int half_cycles(input speed_e spd);
        case (spd)
            SPEED_10:  return HALF_10;
            SPEED_100: return HALF_100;
            default:   return HALF_1000;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_tx_clkgen.sv
// rtl/rgmii_tx_clkgen.sv - byte phase counter, quarter/byte strobes and registered RGMII tx_clk
module rgmii_tx_clkgen
    import rgmii_tx_pkg::*;
(
    input  logic              gtx_clk250,
    input  logic              tx_rst,
    input  logic              mii_sel,
    input  logic [HALF_W-1:0] half_sel,
    output logic              byte_req,
    output logic              active_nx,
    output logic              mii_nx,
    output logic [1:0]        seg_nx,
    output logic              tx_clk
);

    logic              started;
    logic              active;
    logic              mii_cur;
    logic [HALF_W-1:0] half_cur;
    logic [HALF_W-1:0] half_nx;
    logic [HALF_W-1:0] hcnt;
    logic [HALF_W-1:0] hcnt_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [1:0]        seg;
    logic              quarter_edge;
    logic              byte_end;
    int                period;

    // A capture cycle restarts every counter so the new byte always opens with tx_clk high.
    always_comb begin
        quarter_edge = (hcnt == half_cur - HALF_W'(1));
        half_nx      = half_cur;
        mii_nx       = mii_cur;
        cnt_nx       = cnt + CNT_W'(1);
        hcnt_nx      = hcnt + HALF_W'(1);
        seg_nx       = seg;
        active_nx    = active;
        if (byte_req) begin
            half_nx   = half_sel;
            mii_nx    = mii_sel;
            cnt_nx    = '0;
            hcnt_nx   = '0;
            seg_nx    = 2'd0;
            active_nx = 1'b1;
        end else if (quarter_edge) begin
            hcnt_nx = '0;
            seg_nx  = seg + 2'd1;
        end
        period   = (mii_nx ? 4 : 2) * int'(half_nx);
        byte_end = active_nx && (int'(cnt_nx) == period - 1);
    end

    always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
        if (tx_rst) begin
            started  <= 1'b0;
            active   <= 1'b0;
            mii_cur  <= 1'b0;
            half_cur <= '0;
            hcnt     <= '0;
            cnt      <= '0;
            seg      <= 2'd0;
            byte_req <= 1'b0;
            tx_clk   <= 1'b0;
        end else begin
            started  <= 1'b1;
            active   <= active_nx;
            mii_cur  <= mii_nx;
            half_cur <= half_nx;
            hcnt     <= hcnt_nx;
            cnt      <= cnt_nx;
            seg      <= seg_nx;
            byte_req <= !started || byte_end;
            tx_clk   <= active_nx & ~seg_nx[0];
        end
    end

endmodule

// File: rtl/rgmii_tx_sdr_serializer.sv
// rtl/rgmii_tx_sdr_serializer.sv - GMII byte stream to SDR-emulated RGMII TX; RGMII_TX_MII_SPEED_EN adds 10/100 MII mode
module rgmii_tx_sdr_serializer
    import rgmii_tx_pkg::*;
(
    input  logic       gtx_clk250,
    input  logic       tx_rst,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    input  logic [1:0] speed,
    output logic       byte_req,
    output logic       rgmii_tx_clk,
    output logic [3:0] rgmii_txd,
    output logic       rgmii_tx_ctl
);

    logic              mii_sel;
    logic [HALF_W-1:0] half_sel;
    logic              active_nx;
    logic              mii_nx;
    logic [1:0]        seg_nx;
    logic [7:0]        d_q;
    logic [7:0]        d_nx;
    logic              en_q;
    logic              en_nx;
    logic              er_q;
    logic              er_nx;
    logic              hi_nib;

`ifdef RGMII_TX_MII_SPEED_EN
    assign mii_sel  = (speed == SPEED_10) || (speed == SPEED_100);
    assign half_sel = HALF_W'(half_cycles(speed_e'(speed)));
`else
    logic unused_speed;
    assign unused_speed = ^speed;
    assign mii_sel      = 1'b0;
    assign half_sel     = HALF_W'(HALF_1000);
`endif

    rgmii_tx_clkgen u_clkgen (
        .gtx_clk250 (gtx_clk250),
        .tx_rst     (tx_rst),
        .mii_sel    (mii_sel),
        .half_sel   (half_sel),
        .byte_req   (byte_req),
        .active_nx  (active_nx),
        .mii_nx     (mii_nx),
        .seg_nx     (seg_nx),
        .tx_clk     (rgmii_tx_clk)
    );

    // MII repeats each nibble over a full tx_clk period, GMII switches nibble every half-period.
    always_comb begin
        d_nx   = byte_req ? gmii_txd   : d_q;
        en_nx  = byte_req ? gmii_tx_en : en_q;
        er_nx  = byte_req ? gmii_tx_er : er_q;
        hi_nib = mii_nx ? seg_nx[1] : seg_nx[0];
    end

    always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
        if (tx_rst) begin
            d_q          <= 8'd0;
            en_q         <= 1'b0;
            er_q         <= 1'b0;
            rgmii_txd    <= 4'd0;
            rgmii_tx_ctl <= 1'b0;
        end else begin
            d_q          <= d_nx;
            en_q         <= en_nx;
            er_q         <= er_nx;
            rgmii_txd    <= active_nx ? (hi_nib ? d_nx[7:4] : d_nx[3:0]) : 4'd0;
            rgmii_tx_ctl <= active_nx & (seg_nx[0] ? (en_nx ^ er_nx) : en_nx);
        end
    end

endmodule

// File: tb/tb_rgmii_tx_sdr_serializer.sv
// tb/tb_rgmii_tx_sdr_serializer.sv - self-checking bench: gigabit vector table plus randomized reference-model run
`timescale 1ns/1ps
module tb_rgmii_tx_sdr_serializer;

    logic       gtx_clk250 = 1'b0;
    logic       tx_rst     = 1'b1;
    logic [7:0] gmii_txd   = 8'd0;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic [1:0] speed      = 2'b10;
    logic       byte_req;
    logic       rgmii_tx_clk;
    logic [3:0] rgmii_txd;
    logic       rgmii_tx_ctl;

    int total = 0;
    int bad   = 0;

    always #5 gtx_clk250 = ~gtx_clk250;

    rgmii_tx_sdr_serializer dut (
        .gtx_clk250   (gtx_clk250),
        .tx_rst       (tx_rst),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .speed        (speed),
        .byte_req     (byte_req),
        .rgmii_tx_clk (rgmii_tx_clk),
        .rgmii_txd    (rgmii_txd),
        .rgmii_tx_ctl (rgmii_tx_ctl)
    );

    typedef struct {
        logic [1:0] spd;
        logic [7:0] d;
        logic       en;
        logic       er;
    } byte_t;

    typedef struct {
        logic       clk;
        logic [3:0] txd;
        logic       ctl;
    } out_t;

    typedef struct {
        logic [1:0] spd;
        logic [7:0] d;
        logic       en;
        logic       er;
        logic [3:0] lo_txd;
        logic       lo_ctl;
        logic [3:0] hi_txd;
        logic       hi_ctl;
    } vec_t;

    out_t  expq[$];
    byte_t pend[$];

    // Compared word is {byte_req, tx_clk, txd, tx_ctl}.
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got req/clk/txd/ctl=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pins();
        return {byte_req, rgmii_tx_clk, rgmii_txd, rgmii_tx_ctl};
    endfunction

    function automatic int half_of(input logic [1:0] s);
`ifdef RGMII_TX_MII_SPEED_EN
        if (s == 2'b00) return 50;
        if (s == 2'b01) return 5;
`endif
        return 1;
    endfunction

    function automatic bit is_mii(input logic [1:0] s);
`ifdef RGMII_TX_MII_SPEED_EN
        return s < 2'b10;
`else
        return (s == 2'b11) && (s != 2'b11);
`endif
    endfunction

    // Line-level picture of one byte: tx_clk high/low halves, nibble per clock period (MII) or half (GMII).
    task automatic expand(input byte_t b);
        int   h;
        int   nseg;
        out_t o;
        h    = half_of(b.spd);
        nseg = is_mii(b.spd) ? 4 : 2;
        for (int s = 0; s < nseg; s++) begin
            o.clk = (s % 2 == 0);
            o.ctl = (s % 2 == 0) ? b.en : (b.en ^ b.er);
            o.txd = (s < nseg / 2) ? b.d[3:0] : b.d[7:4];
            repeat (h) expq.push_back(o);
        end
    endtask

    function automatic byte_t rand_byte();
        byte_t b;
        int    r;
        b.d  = 8'($urandom);
        b.en = 1'($urandom);
        b.er = 1'($urandom_range(0, 3) == 0);
        r    = $urandom_range(0, 19);
        if (r == 0)      b.spd = 2'b00;
        else if (r < 6)  b.spd = 2'b01;
        else if (r < 13) b.spd = 2'b10;
        else             b.spd = 2'b11;
        return b;
    endfunction

    // One cycle: compare against the model, then feed a byte on capture cycles or junk otherwise.
    task automatic step(input string tag);
        out_t  e;
        logic  req;
        byte_t b;
        @(negedge gtx_clk250);
        if (expq.size() > 0) e = expq.pop_front();
        else e = '{1'b0, 4'd0, 1'b0};
        req = (expq.size() == 0);
        check(tag, pins(), {req, e.clk, e.txd, e.ctl});
        if (req) begin
            if (pend.size() > 0) b = pend.pop_front();
            else b = rand_byte();
            gmii_txd   = b.d;
            gmii_tx_en = b.en;
            gmii_tx_er = b.er;
            speed      = b.spd;
            expand(b);
        end else begin
            gmii_txd   = 8'($urandom);
            gmii_tx_en = 1'($urandom);
            gmii_tx_er = 1'($urandom);
            speed      = 2'($urandom);
        end
    endtask

    task automatic do_reset(input string tag);
        #1 tx_rst = 1'b1;
        #1 check(tag, pins(), 7'd0);
        expq.delete();
        repeat (2) @(negedge gtx_clk250);
        tx_rst = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'b10, 8'hA5, 1'b1, 1'b0, 4'h5, 1'b1, 4'hA, 1'b1};
        tbl[1] = '{2'b10, 8'h00, 1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0};
        tbl[2] = '{2'b11, 8'h00, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1};
        tbl[3] = '{2'b10, 8'h3C, 1'b0, 1'b0, 4'hC, 1'b0, 4'h3, 1'b0};
        tbl[4] = '{2'b11, 8'hFF, 1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 1'b1};
        tbl[5] = '{2'b10, 8'h69, 1'b0, 1'b1, 4'h9, 1'b0, 4'h6, 1'b1};
`ifndef RGMII_TX_MII_SPEED_EN
        tbl[0].spd = 2'b00;
        tbl[3].spd = 2'b01;
`endif

        repeat (3) @(negedge gtx_clk250);
        check("in_reset", pins(), 7'd0);
        tx_rst = 1'b0;
        #1 check("release_edge", pins(), 7'd0);

        for (int i = 0; i < 6; i++) begin
            int n;
            n = 0;
            while (byte_req !== 1'b1 && n < 8) begin
                @(negedge gtx_clk250);
                n++;
            end
            if (i == 0) check("c0_idle", pins(), 7'b1_0_0000_0);
            else check($sformatf("tbl%0d_req", i), {6'd0, byte_req}, 7'd1);
            gmii_txd   = tbl[i].d;
            gmii_tx_en = tbl[i].en;
            gmii_tx_er = tbl[i].er;
            speed      = tbl[i].spd;
            @(negedge gtx_clk250);
            gmii_txd   = ~tbl[i].d;
            gmii_tx_en = ~tbl[i].en;
            check($sformatf("tbl%0d_lo", i), pins(), {1'b0, 1'b1, tbl[i].lo_txd, tbl[i].lo_ctl});
            @(negedge gtx_clk250);
            check($sformatf("tbl%0d_hi", i), pins(), {1'b1, 1'b0, tbl[i].hi_txd, tbl[i].hi_ctl});
        end

        do_reset("reset_after_tbl");
        pend.push_back('{2'b01, 8'h3C, 1'b1, 1'b0});
        pend.push_back('{2'b00, 8'h7E, 1'b1, 1'b0});
        pend.push_back('{2'b10, 8'h12, 1'b1, 1'b0});
        pend.push_back('{2'b10, 8'h34, 1'b1, 1'b1});
        pend.push_back('{2'b10, 8'h56, 1'b0, 1'b1});
        repeat (240) step("scenario");

        do_reset("reset_before_mid");
        pend.push_back('{2'b01, 8'hC3, 1'b1, 1'b0});
        repeat (8) step("pre_mid");
        @(posedge gtx_clk250);
        do_reset("reset_mid_byte");
        pend.push_back('{2'b01, 8'h5A, 1'b1, 1'b1});
        repeat (30) step("post_mid");

        repeat (1500) step("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
